// File: rtl/writeback_if.sv
// Shared core types and the AXI-stream style interface carrying wb_t beats
// from the memory stage into writeback.
package core;
    typedef logic [31:0] word_t;
    typedef logic [4:0]  reg_addr_t;

    typedef enum logic [4:0] {
        NULL, LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LOAD_BYTE, LOAD_HALF, LOAD_WORD, LOAD_BYTE_U, LOAD_HALF_U,
        STORE_BYTE, STORE_HALF, STORE_WORD,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        FENCE, ECALL, EBREAK
    } op_t;

    typedef struct packed {
        op_t op;
    } ctrl_t;

    typedef struct packed {
        reg_addr_t addr;
        word_t     data;
    } rd_t;

    typedef struct packed {
        rd_t rd;
    } data_t;

    typedef struct packed {
        ctrl_t ctrl;
        data_t data;
    } wb_t;

    function automatic logic is_store(input op_t op);
        return op inside {STORE_BYTE, STORE_HALF, STORE_WORD};
    endfunction

    function automatic logic is_branch(input op_t op);
        return op inside {BEQ, BNE, BLT, BGE, BLTU, BGEU};
    endfunction
endpackage

interface axis;
    logic        tvalid;
    logic        tready;
    core::wb_t   tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/writeback.sv
// Writeback stage: commits wb_t beats into the 32x32 register file, counts retirements.
// Optional WRITEBACK_BYPASS_EN: same-cycle write-through forwarding on both read ports.
module writeback #(
    parameter int unsigned XLEN         = 32,
    parameter logic [63:0] INSTRET_INIT = 64'h0
) (
    input  logic            aclk,
    input  logic            aresetn,
    axis.slave              up,
    input  logic            hold,
    input  logic [4:0]      rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    output logic            retire,
    output logic [63:0]     instret
);

    if (XLEN != $bits(core::word_t)) begin : g_bad_xlen
        $error("writeback: XLEN must equal the width of core::word_t");
    end

    logic [XLEN-1:0] r_regs [0:31];
    logic            r_retire;
    logic [63:0]     r_instret;

    core::op_t       w_op;
    logic [4:0]      w_rd_addr;
    logic [XLEN-1:0] w_rd_data;
    logic            w_accept;
    logic            w_we;
    logic [XLEN-1:0] w_rs1;
    logic [XLEN-1:0] w_rs2;

    assign up.tready = ~hold;

    always_comb begin
        w_op      = up.tdata.ctrl.op;
        w_rd_addr = up.tdata.data.rd.addr;
        w_rd_data = up.tdata.data.rd.data;
        w_accept  = up.tvalid & ~hold;
        w_we      = w_accept & (w_op != core::NULL) & ~core::is_store(w_op)
                  & ~core::is_branch(w_op) & (w_rd_addr != '0);
    end

    // Array is deliberately not reset; a beat arriving in the reset cycle is dropped.
    always_ff @(posedge aclk) begin
        if (aresetn && w_we) begin
            r_regs[w_rd_addr] <= w_rd_data;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_retire  <= 1'b0;
            r_instret <= INSTRET_INIT;
        end else begin
            r_retire <= w_accept;
            if (w_accept) begin
                r_instret <= r_instret + 64'd1;
            end
        end
    end

    // w_we already excludes rd=0, so forwarding never overrides the x0 zero.
    always_comb begin
        w_rs1 = (rs1_addr == '0) ? '0 : r_regs[rs1_addr];
        w_rs2 = (rs2_addr == '0) ? '0 : r_regs[rs2_addr];
`ifdef WRITEBACK_BYPASS_EN
        if (w_we && (rs1_addr == w_rd_addr)) begin
            w_rs1 = w_rd_data;
        end
        if (w_we && (rs2_addr == w_rd_addr)) begin
            w_rs2 = w_rd_data;
        end
`else
`endif
    end

    assign rs1_data = w_rs1;
    assign rs2_data = w_rs2;
    assign retire   = r_retire;
    assign instret  = r_instret;

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: scoreboard of expected commits plus directed scenarios.
module tb_writeback;
    localparam logic [63:0] INIT1 = 64'hFFFF_FFFF_FFFF_FFFE;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        aresetn;
    logic        hold;
    logic [4:0]  rs1_addr, rs2_addr, rs1b_addr, rs2b_addr;
    logic [31:0] rs1_data, rs2_data, rs1b_data, rs2b_data;
    logic        retire0, retire1;
    logic [63:0] instret0, instret1;

    axis up0();
    axis up1();

    writeback #(.XLEN(32), .INSTRET_INIT(64'h0)) dut0 (
        .aclk(clk), .aresetn(aresetn), .up(up0), .hold(hold),
        .rs1_addr(rs1_addr), .rs1_data(rs1_data),
        .rs2_addr(rs2_addr), .rs2_data(rs2_data),
        .retire(retire0), .instret(instret0)
    );

    writeback #(.XLEN(32), .INSTRET_INIT(INIT1)) dut1 (
        .aclk(clk), .aresetn(aresetn), .up(up1), .hold(hold),
        .rs1_addr(rs1b_addr), .rs1_data(rs1b_data),
        .rs2_addr(rs2b_addr), .rs2_data(rs2b_data),
        .retire(retire1), .instret(instret1)
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [63:0] m0 = 64'h0;
    logic [63:0] m1 = INIT1;
    logic [63:0] e0, e1;
    bit mon_en = 1'b0;

    // Advance one clock; the model decides acceptance from the bench's own drive values.
    task automatic tick();
        bit rst, c0, c1;
        rst = !aresetn;
        c0  = up0.tvalid && !hold;
        c1  = up1.tvalid && !hold;
        @(posedge clk);
        if (rst) begin
            m0 = 64'h0;
            m1 = INIT1;
        end else begin
            if (c0) begin m0 = m0 + 64'd1; q0.push_back(m0); end
            if (c1) begin m1 = m1 + 64'd1; q1.push_back(m1); end
        end
        #1;
    endtask

    task automatic drive0(input core::op_t op, input logic [4:0] rd, input logic [31:0] d);
        up0.tvalid             = 1'b1;
        up0.tdata.ctrl.op      = op;
        up0.tdata.data.rd.addr = rd;
        up0.tdata.data.rd.data = d;
    endtask

    task automatic write0(input core::op_t op, input logic [4:0] rd, input logic [31:0] d);
        drive0(op, rd, d);
        tick();
        up0.tvalid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (q0.size() != 0) begin
                e0 = q0.pop_front();
                checks++;
                if (retire0 !== 1'b1 || instret0 !== e0) begin
                    errors++;
                    $display("FAIL commit0: retire=%b instret=%h, required retire=1 instret=%h", retire0, instret0, e0);
                end
            end else begin
                checks++;
                if (retire0 !== 1'b0) begin
                    errors++;
                    $display("FAIL idle0: retire=%b, required 0", retire0);
                end
            end
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                checks++;
                if (retire1 !== 1'b1 || instret1 !== e1) begin
                    errors++;
                    $display("FAIL commit1: retire=%b instret=%h, required retire=1 instret=%h", retire1, instret1, e1);
                end
            end else begin
                checks++;
                if (retire1 !== 1'b0) begin
                    errors++;
                    $display("FAIL idle1: retire=%b, required 0", retire1);
                end
            end
        end
    end

    task automatic test_reset();
        aresetn = 1'b0; hold = 1'b0;
        up0.tvalid = 1'b0; up1.tvalid = 1'b0;
        up0.tdata = '0; up1.tdata = '0;
        rs1_addr = '0; rs2_addr = '0; rs1b_addr = '0; rs2b_addr = '0;
        tick(); tick();
        aresetn = 1'b1;
        mon_en  = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (instret0 !== 64'h0) begin errors++; $display("FAIL reset_instret: got %h, required 0", instret0); end
        checks++;
        if (retire0 !== 1'b0) begin errors++; $display("FAIL reset_retire: got %b, required 0", retire0); end
        checks++;
        if (up0.tready !== 1'b1) begin errors++; $display("FAIL reset_tready: got %b, required 1", up0.tready); end
        checks++;
        if (rs1_data !== 32'h0) begin errors++; $display("FAIL reset_x0: got %h, required 0", rs1_data); end
        checks++;
        if (instret1 !== INIT1) begin errors++; $display("FAIL reset_init1: got %h, required %h", instret1, INIT1); end
        hold = 1'b1; #1;
        checks++;
        if (up0.tready !== 1'b0) begin errors++; $display("FAIL hold_tready: got %b, required 0", up0.tready); end
        hold = 1'b0;
    endtask

    task automatic test_alu();
        write0(core::ADD, 5'd5, 32'h1111_1111);
        drive0(core::ADD, 5'd5, 32'hDEAD_BEEF);
        rs1_addr = 5'd5; rs2_addr = 5'd5; #1;
        checks++;
`ifdef WRITEBACK_BYPASS_EN
        if (rs1_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_commit_cycle: got %h, required %h", rs1_data, 32'hDEAD_BEEF); end
`else
        if (rs1_data !== 32'h1111_1111) begin errors++; $display("FAIL alu_commit_cycle: got %h, required %h", rs1_data, 32'h1111_1111); end
`endif
        tick();
        up0.tvalid = 1'b0; #1;
        checks++;
        if (rs1_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_rs1: got %h, required %h", rs1_data, 32'hDEAD_BEEF); end
        checks++;
        if (rs2_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_rs2_alias: got %h, required %h", rs2_data, 32'hDEAD_BEEF); end
        checks++;
        if (retire0 !== 1'b1 || instret0 !== 64'd2) begin errors++; $display("FAIL alu_count: retire=%b instret=%h, required 1 and 2", retire0, instret0); end
        tick();
        checks++;
        if (retire0 !== 1'b0) begin errors++; $display("FAIL alu_single_pulse: got %b, required 0", retire0); end
    endtask

    task automatic test_no_write();
        logic [63:0] base;
        write0(core::ADD, 5'd7, 32'h0000_0077);
        base = m0;
        drive0(core::ADD, 5'd0, 32'h0000_1234);        tick();
        drive0(core::STORE_WORD, 5'd7, 32'h0000_FFFF); tick();
        drive0(core::BEQ, 5'd7, 32'h0000_0BAD);        tick();
        up0.tvalid = 1'b0;
        rs1_addr = 5'd0; rs2_addr = 5'd7; #1;
        checks++;
        if (rs1_data !== 32'h0) begin errors++; $display("FAIL x0_write: got %h, required 0", rs1_data); end
        checks++;
        if (rs2_data !== 32'h77) begin errors++; $display("FAIL x7_kept: got %h, required 77", rs2_data); end
        checks++;
        if (instret0 !== base + 64'd3) begin errors++; $display("FAIL nowrite_count: got %h, required %h", instret0, base + 64'd3); end
        drive0(core::NULL, 5'd7, 32'h0000_CAFE); tick();
        up0.tvalid = 1'b0; #1;
        checks++;
        if (rs2_data !== 32'h77 || instret0 !== base + 64'd4) begin
            errors++; $display("FAIL null_op: x7=%h instret=%h, required 77 and %h", rs2_data, instret0, base + 64'd4);
        end
    endtask

    task automatic test_back_to_back();
        rs1_addr = 5'd10;
        drive0(core::ADD, 5'd10, 32'hAAAA_0001); tick();
        checks++;
        if (rs1_data !== 32'hAAAA_0001) begin errors++; $display("FAIL b2b_first: got %h, required %h", rs1_data, 32'hAAAA_0001); end
        drive0(core::SUB, 5'd10, 32'hBBBB_0002); tick();
        up0.tvalid = 1'b0; #1;
        checks++;
        if (rs1_data !== 32'hBBBB_0002) begin errors++; $display("FAIL b2b_second: got %h, required %h", rs1_data, 32'hBBBB_0002); end
    endtask

    task automatic test_hold();
        logic [63:0] base;
        write0(core::ADD, 5'd9, 32'h0);
        base = m0;
        hold = 1'b1;
        drive0(core::ADD, 5'd9, 32'hA5A5_A5A5);
        rs1_addr = 5'd9;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (up0.tready !== 1'b0) begin errors++; $display("FAIL hold_ready_%0d: got %b, required 0", i, up0.tready); end
        end
        checks++;
        if (rs1_data !== 32'h0 || instret0 !== base) begin
            errors++; $display("FAIL hold_nocommit: x9=%h instret=%h, required 0 and %h", rs1_data, instret0, base);
        end
        hold = 1'b0;
        tick();
        up0.tvalid = 1'b0; #1;
        checks++;
        if (rs1_data !== 32'hA5A5_A5A5 || instret0 !== base + 64'd1) begin
            errors++; $display("FAIL hold_release: x9=%h instret=%h, required a5a5a5a5 and %h", rs1_data, instret0, base + 64'd1);
        end
    endtask

    task automatic test_hold_toggle();
        logic [63:0] base;
        int n;
        bit c;
        base = m0; n = 0;
        rs1_addr = 5'd11;
        drive0(core::ADD, 5'd11, 32'h1000);
        for (int cyc = 0; cyc < 20 && n < 4; cyc++) begin
            hold = ~hold;
            c = !hold;
            tick();
            if (c) begin
                n++;
                if (n < 4) drive0(core::ADD, 5'd11, 32'h1000 + 32'(n));
            end
        end
        up0.tvalid = 1'b0; hold = 1'b0; #1;
        checks++;
        if (instret0 !== base + 64'd4 || rs1_data !== 32'h1003) begin
            errors++; $display("FAIL toggle: instret=%h x11=%h, required %h and 1003", instret0, rs1_data, base + 64'd4);
        end
    endtask

    task automatic test_wrap();
        rs1b_addr = 5'd1;
        up1.tvalid = 1'b1;
        up1.tdata.ctrl.op = core::ADD;
        up1.tdata.data.rd.addr = 5'd1;
        up1.tdata.data.rd.data = 32'h1;
        tick();
        checks++;
        if (instret1 !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL wrap_max: got %h, required ffffffffffffffff", instret1); end
        up1.tdata.data.rd.data = 32'h2;
        tick();
        up1.tvalid = 1'b0; #1;
        checks++;
        if (instret1 !== 64'h0) begin errors++; $display("FAIL wrap_zero: got %h, required 0", instret1); end
        checks++;
        if (rs1b_data !== 32'h2) begin errors++; $display("FAIL wrap_data: got %h, required 2", rs1b_data); end
    endtask

    task automatic test_reset_midstream();
        write0(core::ADD, 5'd3, 32'h33);
        drive0(core::ADD, 5'd3, 32'h55);
        aresetn = 1'b0;
        tick();
        up0.tvalid = 1'b0;
        aresetn = 1'b1;
        rs1_addr = 5'd3; #1;
        checks++;
        if (retire0 !== 1'b0 || instret0 !== 64'h0) begin
            errors++; $display("FAIL midreset_count: retire=%b instret=%h, required 0 and 0", retire0, instret0);
        end
        checks++;
        if (instret1 !== INIT1) begin errors++; $display("FAIL midreset_init1: got %h, required %h", instret1, INIT1); end
        checks++;
        if (rs1_data !== 32'h33) begin errors++; $display("FAIL midreset_x3: got %h, required 33", rs1_data); end
        tick();
        checks++;
        if (retire0 !== 1'b0) begin errors++; $display("FAIL midreset_retire: got %b, required 0", retire0); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_no_write();
        test_back_to_back();
        test_hold();
        test_hold_toggle();
        test_wrap();
        test_reset_midstream();
        tick(); tick();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: %0d/%0d entries left, required 0", q0.size(), q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
